// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: CDB payload layout and EU count.
package expipe_pkg;

  localparam int unsigned EU_N      = 4;
  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned EXCEPT_W  = 5;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      res_value;
    logic                 except_raised;
    logic [EXCEPT_W-1:0]  except_code;
  } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of EU results onto the CDB with a one-slot output register.
// Optional LEN5_CDB_EXCEPT_PRIO_EN: excepting results win over normal ones.
module cdb_arbiter #(
  parameter int unsigned N_EU  = expipe_pkg::EU_N,
  parameter int unsigned PTR_W = $clog2(N_EU)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [N_EU-1:0]       eu_valid_i,
  output logic [N_EU-1:0]       eu_ready_o,
  input  expipe_pkg::cdb_data_t eu_data_i [N_EU],
  output logic                  cdb_valid_o,
  input  logic                  cdb_ready_i,
  output expipe_pkg::cdb_data_t cdb_data_o,
  output logic [PTR_W-1:0]      cdb_grant_idx_o
);

  logic                  r_valid;
  expipe_pkg::cdb_data_t r_data;
  logic [PTR_W-1:0]      r_idx;
  logic [PTR_W-1:0]      r_ptr;

  logic                  w_slot_free;
  logic                  w_grant_vld;
  logic [PTR_W-1:0]      w_grant_idx;
  logic [N_EU-1:0]       w_ready;
  logic                  w_fire;
  logic [PTR_W-1:0]      w_order [N_EU];

  // w_order[i] is the EU with the i-th highest priority, starting at ptr+1.
  always_comb begin
    for (int unsigned i = 0; i < N_EU; i++) begin
      w_order[i] = PTR_W'((32'(r_ptr) + i + 32'd1) % N_EU);
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
`ifdef LEN5_CDB_EXCEPT_PRIO_EN
    for (int unsigned i = 0; i < N_EU; i++) begin
      if (!w_grant_vld && eu_valid_i[w_order[i]] && eu_data_i[w_order[i]].except_raised) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_order[i];
      end
    end
`endif
    for (int unsigned i = 0; i < N_EU; i++) begin
      if (!w_grant_vld && eu_valid_i[w_order[i]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_order[i];
      end
    end
  end

  assign w_slot_free = !r_valid || cdb_ready_i;

  always_comb begin
    w_ready = '0;
    if (rst_ni && w_slot_free && !flush_i && w_grant_vld) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_fire = |w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_ptr   <= PTR_W'(N_EU - 1);
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= eu_data_i[w_grant_idx];
      r_idx   <= w_grant_idx;
      r_ptr   <= w_grant_idx;
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  assign eu_ready_o      = w_ready;
  assign cdb_valid_o     = r_valid;
  assign cdb_data_o      = r_data;
  assign cdb_grant_idx_o = r_idx;

endmodule
